// File: rtl/call_stack_if.sv
// Pipeline-side bundle for the hardware return-address stack.
// master drives the call-stack controls; slave is the stack itself.
interface call_stack_if #(
  parameter int DEPTH = 16,
  parameter int AW    = 14
);
  localparam int SPW = $clog2(DEPTH) + 1;

  logic           call_stack_enable;
  logic           mem_wen;
  logic           call_stk_addr_sel;
  logic [AW-1:0]  call_addr;
  logic [AW-1:0]  link_addr;
  logic           stall;
  logic           flush;
  logic [AW-1:0]  ret_addr;
  logic           ret_valid;
  logic [SPW-1:0] sp;
  logic           overflow;
  logic           underflow;

  modport master (
    output call_stack_enable, mem_wen, call_stk_addr_sel, call_addr, link_addr,
           stall, flush,
    input  ret_addr, ret_valid, sp, overflow, underflow
  );

  modport slave (
    input  call_stack_enable, mem_wen, call_stk_addr_sel, call_addr, link_addr,
           stall, flush,
    output ret_addr, ret_valid, sp, overflow, underflow
  );
endinterface

// File: rtl/call_stack_unit.sv
// Memory-stage return-address stack with registered pop output and sticky flags.
// Build option CALL_STACK_WRAP_EN: circular stack, a push while full overwrites the oldest entry.
module call_stack_unit #(
  parameter int DEPTH = 16,
  parameter int AW    = 14
) (
  input  logic         clock,
  input  logic         nreset,
  call_stack_if.slave  bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int SPW = PW + 1;

  logic [AW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  ret_addr_q, ret_addr_d;
  logic           ret_valid_q, ret_valid_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic           push, pop, full, empty;
  logic [AW-1:0]  push_src;
  logic [PW-1:0]  rd_ptr;

  assign push     = bus.call_stack_enable &  bus.mem_wen & ~bus.stall;
  assign pop      = bus.call_stack_enable & ~bus.mem_wen & ~bus.stall;
  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign push_src = bus.call_stk_addr_sel ? bus.link_addr : bus.call_addr;
  // wr_ptr tracks the next free slot modulo DEPTH, so the top entry sits one below it.
  assign rd_ptr   = wr_ptr_q - 1'b1;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    sp_d        = sp_q;
    ret_addr_d  = ret_addr_q;
    ret_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.flush) begin
      wr_ptr_d    = '0;
      sp_d        = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (push) begin
      if (!full) begin
        mem_d[wr_ptr_q] = push_src;
        wr_ptr_d        = wr_ptr_q + 1'b1;
        sp_d            = sp_q + 1'b1;
      end else begin
`ifdef CALL_STACK_WRAP_EN
        mem_d[wr_ptr_q] = push_src;
        wr_ptr_d        = wr_ptr_q + 1'b1;
`else
        overflow_d      = 1'b1;
`endif
      end
    end else if (pop) begin
      ret_valid_d = 1'b1;
      if (!empty) begin
        ret_addr_d = mem_q[rd_ptr];
        wr_ptr_d   = rd_ptr;
        sp_d       = sp_q - 1'b1;
      end else begin
        ret_addr_d  = '0;
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      wr_ptr_q    <= '0;
      sp_q        <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      sp_q        <= sp_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.ret_addr  = ret_addr_q;
  assign bus.ret_valid = ret_valid_q;
  assign bus.sp        = sp_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_call_stack_unit.sv
// Directed bench for call_stack_unit; expectations follow CALL_STACK_WRAP_EN when defined.
module tb_call_stack_unit;
  logic clock;
  logic nreset;
  int   checks = 0;
  int   errors = 0;

  call_stack_if #(.DEPTH(16), .AW(14)) bus ();

  call_stack_unit #(.DEPTH(16), .AW(14)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_idle();
    bus.call_stack_enable = 1'b0;
    bus.mem_wen           = 1'b0;
    tick();
  endtask

  task automatic do_push(input logic [13:0] a);
    bus.call_stack_enable = 1'b1;
    bus.mem_wen           = 1'b1;
    bus.call_stk_addr_sel = 1'b0;
    bus.call_addr         = a;
    tick();
  endtask

  task automatic do_pop();
    bus.call_stack_enable = 1'b1;
    bus.mem_wen           = 1'b0;
    tick();
  endtask

  task automatic do_flush();
    bus.call_stack_enable = 1'b0;
    bus.flush             = 1'b1;
    tick();
    bus.flush             = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    tick();
    tick();
    checks++; if (bus.sp !== 5'd0) begin errors++; $display("FAIL reset_sp got=%0d exp=0", bus.sp); end
    checks++; if (bus.ret_addr !== 14'h0) begin errors++; $display("FAIL reset_ret_addr got=%h exp=0", bus.ret_addr); end
    checks++; if (bus.ret_valid !== 1'b0) begin errors++; $display("FAIL reset_ret_valid got=%b exp=0", bus.ret_valid); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%b%b exp=00", bus.overflow, bus.underflow);
    end
    nreset = 1'b1;
    do_idle();
  endtask

  task automatic test_push_pop();
    do_push(14'h1234);
    checks++; if (bus.sp !== 5'd1) begin errors++; $display("FAIL pp_sp1 got=%0d exp=1", bus.sp); end
    checks++; if (bus.ret_valid !== 1'b0) begin errors++; $display("FAIL pp_rv_push got=%b exp=0", bus.ret_valid); end
    do_pop();
    checks++; if (bus.ret_addr !== 14'h1234) begin errors++; $display("FAIL pp_ret_addr got=%h exp=1234", bus.ret_addr); end
    checks++; if (bus.ret_valid !== 1'b1) begin errors++; $display("FAIL pp_ret_valid got=%b exp=1", bus.ret_valid); end
    checks++; if (bus.sp !== 5'd0) begin errors++; $display("FAIL pp_sp0 got=%0d exp=0", bus.sp); end
    do_idle();
    checks++; if (bus.ret_valid !== 1'b0) begin errors++; $display("FAIL pp_rv_idle got=%b exp=0", bus.ret_valid); end
    checks++; if (bus.ret_addr !== 14'h1234) begin errors++; $display("FAIL pp_hold got=%h exp=1234", bus.ret_addr); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL pp_flags got=%b%b exp=00", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_link_sel();
    bus.call_stack_enable = 1'b1;
    bus.mem_wen           = 1'b1;
    bus.call_stk_addr_sel = 1'b1;
    bus.call_addr         = 14'h3FFF;
    bus.link_addr         = 14'h0042;
    tick();
    bus.call_stk_addr_sel = 1'b0;
    do_pop();
    checks++; if (bus.ret_addr !== 14'h0042) begin errors++; $display("FAIL link_ret_addr got=%h exp=0042", bus.ret_addr); end
    do_idle();
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp;
    do_push(14'h0111);
    do_push(14'h0222);
    do_pop();
    checks++; if (bus.ret_addr !== 14'h0222 || bus.ret_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_pop1 got=%h/%b exp=0222/1", bus.ret_addr, bus.ret_valid);
    end
    do_pop();
    checks++; if (bus.ret_addr !== 14'h0111 || bus.ret_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_pop2 got=%h/%b exp=0111/1", bus.ret_addr, bus.ret_valid);
    end
    for (int i = 0; i < 3; i++) begin
      exp = 14'h0500 + 14'(i);
      do_push(exp);
      do_pop();
      checks++; if (bus.ret_addr !== exp) begin errors++; $display("FAIL b2b_pushpop%0d got=%h exp=%h", i, bus.ret_addr, exp); end
    end
    do_idle();
  endtask

  task automatic test_overflow();
    logic [13:0] exp;
    for (int i = 1; i <= 16; i++) do_push(14'(i));
    checks++; if (bus.sp !== 5'd16) begin errors++; $display("FAIL ovf_sp_full got=%0d exp=16", bus.sp); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", bus.overflow); end
    do_push(14'h0099);
    checks++; if (bus.sp !== 5'd16) begin errors++; $display("FAIL ovf_sp got=%0d exp=16", bus.sp); end
`ifdef CALL_STACK_WRAP_EN
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_flag got=%b exp=0", bus.overflow); end
`else
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
`endif
    for (int k = 0; k < 16; k++) begin
      do_pop();
`ifdef CALL_STACK_WRAP_EN
      exp = (k == 0) ? 14'h0099 : 14'(17 - k);
`else
      exp = 14'(16 - k);
`endif
      checks++; if (bus.ret_addr !== exp || bus.ret_valid !== 1'b1) begin
        errors++; $display("FAIL ovf_pop%0d got=%h/%b exp=%h/1", k, bus.ret_addr, bus.ret_valid, exp);
      end
    end
    checks++; if (bus.sp !== 5'd0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL ovf_drained got=%0d/%b exp=0/0", bus.sp, bus.underflow);
    end
    do_idle();
  endtask

  task automatic test_underflow();
    do_flush();
    do_pop();
    checks++; if (bus.ret_addr !== 14'h0 || bus.ret_valid !== 1'b1) begin
      errors++; $display("FAIL unf_pop got=%h/%b exp=0000/1", bus.ret_addr, bus.ret_valid);
    end
    checks++; if (bus.underflow !== 1'b1 || bus.sp !== 5'd0) begin
      errors++; $display("FAIL unf_flag got=%b/%0d exp=1/0", bus.underflow, bus.sp);
    end
    do_push(14'h0777);
    do_pop();
    do_idle();
    do_idle();
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky got=%b exp=1", bus.underflow); end
  endtask

  task automatic test_stall();
    do_flush();
    do_push(14'h0AAA);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_pop();
      checks++; if (bus.sp !== 5'd1 || bus.ret_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got=%0d/%b exp=1/0", i, bus.sp, bus.ret_valid);
      end
    end
    bus.stall = 1'b0;
    do_pop();
    checks++; if (bus.ret_addr !== 14'h0AAA || bus.ret_valid !== 1'b1 || bus.sp !== 5'd0) begin
      errors++; $display("FAIL stall_release got=%h/%b/%0d exp=0aaa/1/0", bus.ret_addr, bus.ret_valid, bus.sp);
    end
    do_idle();
  endtask

  task automatic test_reset_mid();
    do_push(14'h0101);
    do_push(14'h0202);
    do_push(14'h0303);
    bus.call_stack_enable = 1'b1;
    bus.mem_wen           = 1'b0;
    nreset                = 1'b0;
    tick();
    checks++; if (bus.sp !== 5'd0 || bus.ret_valid !== 1'b0 || bus.ret_addr !== 14'h0) begin
      errors++; $display("FAIL rstmid got=%0d/%b/%h exp=0/0/0000", bus.sp, bus.ret_valid, bus.ret_addr);
    end
    nreset = 1'b1;
    do_idle();
  endtask

  task automatic test_flush();
    do_pop();
    for (int i = 0; i < 17; i++) do_push(14'h0020 + 14'(i));
    checks++; if (bus.underflow !== 1'b1 || bus.sp !== 5'd16) begin
      errors++; $display("FAIL flush_pre got=%b/%0d exp=1/16", bus.underflow, bus.sp);
    end
`ifndef CALL_STACK_WRAP_EN
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf got=%b exp=1", bus.overflow); end
`endif
    bus.call_stack_enable = 1'b1;
    bus.mem_wen           = 1'b0;
    bus.stall             = 1'b1;
    bus.flush             = 1'b1;
    tick();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    checks++; if (bus.sp !== 5'd0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.ret_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear got=%0d/%b/%b/%b exp=0/0/0/0", bus.sp, bus.overflow, bus.underflow, bus.ret_valid);
    end
    do_pop();
    checks++; if (bus.underflow !== 1'b1 || bus.ret_addr !== 14'h0) begin
      errors++; $display("FAIL flush_empty got=%b/%h exp=1/0000", bus.underflow, bus.ret_addr);
    end
    do_idle();
  endtask

  initial begin
    nreset                = 1'b0;
    bus.call_stack_enable = 1'b0;
    bus.mem_wen           = 1'b0;
    bus.call_stk_addr_sel = 1'b0;
    bus.call_addr         = '0;
    bus.link_addr         = '0;
    bus.stall             = 1'b0;
    bus.flush             = 1'b0;
    test_reset();
    test_push_pop();
    test_link_sel();
    test_back_to_back();
    test_overflow();
    test_underflow();
    test_stall();
    test_reset_mid();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/call_stack_unit.md
# call_stack_unit

Hardware return-address stack in the memory stage, driven directly by the call-stack controls registered in the execution/memory pipeline register. A CALL pushes a 14-bit program address. A RET pops one and presents it to fetch one cycle later. Overflow and underflow are flagged sticky for the SFR file.

## Interface
Parameters:
- DEPTH, 16, number of stack entries; power of two, 2..64
- AW, 14, return-address width; matches call_addr

Ports:
- clock  in  1  system clock
- nreset  in  1  reset, synchronous, active-low
- call_stack_enable  in  1  stack operation this cycle
- mem_wen  in  1  qualifies the operation: 1 = push, 0 = pop
- call_stk_addr_sel  in  1  push source: 0 = call_addr, 1 = link_addr
- call_addr  in  AW  explicit push value from the pipeline register
- link_addr  in  AW  PC+1 of the CALL instruction
- stall  in  1  freezes all state; ignores the operation
- flush  in  1  empties the stack; clears the flags
- ret_addr  out  AW  popped address, registered
- ret_valid  out  1  one-cycle pulse with ret_addr
- sp  out  log2(DEPTH)+1  current entry count, 0..DEPTH
- overflow  out  1  sticky, push attempted while full
- underflow  out  1  sticky, pop attempted while empty

## Operation
- Storage is DEPTH×AW registers plus a write pointer. sp is the entry count.
- push = call_stack_enable & mem_wen & !stall.
- pop = call_stack_enable & !mem_wen & !stall.
- Push and pop are mutually exclusive by encoding.
- Push, not full: mem[sp] <= selected source; sp <= sp+1.
- Push, full: write dropped; sp unchanged; overflow <= 1.
- Pop, not empty: ret_addr <= mem[sp-1]; sp <= sp-1; ret_valid <= 1.
- Pop, empty: ret_addr <= 0; ret_valid <= 1; underflow <= 1; sp stays 0.
- ret_valid is 0 on every cycle without a pop.
- ret_addr holds its last value when no pop occurs.
- flush has priority over push, pop and stall:
  - sp <= 0; overflow <= 0; underflow <= 0; ret_valid <= 0.
  - Memory contents are not cleared.
- stall without flush holds sp, the flags, ret_addr and memory. ret_valid <= 0.
- Reset values: sp=0, ret_addr=0, ret_valid=0, overflow=0, underflow=0. Memory is not reset.

## Timing
- Push: written on the rising edge where push=1. sp shows the new count on the next cycle.
- Pop: one-cycle latency. ret_addr and ret_valid are valid the cycle after the edge where pop=1.
- Back-to-back operations are allowed on every cycle.
- Pop directly after push returns the just-pushed value. No bypass is needed because writes are edge-registered.
- Sequence push A, push B, pop, pop returns B, then A on consecutive cycles.
- Reset asserted mid-sequence: all outputs take their reset values at that edge. A pop in flight is discarded (ret_valid=0 next cycle).
- No combinational path from any input to any output.

## Configuration
- CALL_STACK_WRAP_EN
  - Defined: the stack is circular. A push while full overwrites the oldest entry; sp stays DEPTH; overflow is not set. Deep recursion therefore loses the oldest frames silently.
  - Undefined: a push while full is dropped and sets overflow, as in Operation.
  - Pop behaviour is identical in both builds.

## Test plan
- Reset, then push call_addr=0x1234 with sel=0, then pop → next cycle ret_addr=0x1234, ret_valid=1; sp goes 0→1→0; no flags.
- Push link_addr=0x0042 with sel=1 and call_addr=0x3FFF, then pop → ret_addr=0x0042.
- Push 0x0001..0x0010 (16 entries), then a 17th push of 0x0099 → without the macro: sp=16, overflow=1; 16 pops return 0x0010..0x0001. With CALL_STACK_WRAP_EN: overflow=0; pops return 0x0099, 0x0010..0x0002.
- Pop on an empty stack → ret_addr=0, ret_valid=1, underflow=1 and stays 1 until flush or reset.
- Push 0x0AAA, then hold stall=1 with a pop request for 3 cycles → sp=1, ret_valid=0 throughout. Release stall with the pop still requested → ret_addr=0x0AAA.
- Push 3 entries, assert nreset=0 on the same cycle as a pop → next cycle sp=0, ret_valid=0, ret_addr=0. flush likewise clears sp and both flags.
